// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO. Optional multiply early termination
// is enabled by defining MDU_EARLY_TERM_EN.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic             a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic [W2-1:0]    prod_fix;

  assign a_neg     = op[0] & a[WIDTH-1];
  assign b_neg     = op[0] & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  // Divide: acc holds {remainder, dividend bits still to be shifted in / quotient bits}
  assign rem_sh    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, opb_q};
  assign prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          dz_d    = 1'b0;
          dbz_d   = 1'b0;
          cnt_d   = '0;
          opb_d   = b_mag;
          mcand_d = {{WIDTH{1'b0}}, a_mag};
          state_d = StCalc;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            if (b == '0) begin
              // Raw dividend is kept so it can be returned unmodified in hi
              dz_d    = 1'b1;
              acc_d   = {{WIDTH{1'b0}}, a};
              state_d = StFin;
            end
          end else begin
            acc_d = '0;
`ifdef MDU_EARLY_TERM_EN
            if (b_mag == '0) state_d = StFin;
`endif
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            if (opb_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
          end
          if (last_iter) state_d = StFin;
`ifdef MDU_EARLY_TERM_EN
          if (!op_q[1] && (opb_q[WIDTH-1:1] == '0)) state_d = StFin;
`endif
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d  = acc_q[WIDTH-1:0];
            lo_d  = '1;
            dbz_d = 1'b1;
          end else if (op_q[1]) begin
            lo_d = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level reference model plus directed literal checks.
// Latency expectations follow MDU_EARLY_TERM_EN when it is defined.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: r = {32'b0, x} * {32'b0, y};
      2'b01: r = 64'(sx * sy);
      2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
    endcase
    return r;
  endfunction

  // Cycles from start acceptance to the done cycle
  function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
    int l;
    logic [31:0] m;
    l = W + 2;
    m = (o[0] && y[31]) ? -y : y;
    if (o[1] && y == 0) l = 2;
`ifdef MDU_EARLY_TERM_EN
    else if (!o[1]) begin
      l = 2;
      for (int i = 0; i < 32; i++) if (m[i]) l = 3 + i;
    end
`endif
    return l;
  endfunction

  int           m_left = 0;
  logic         m_done, m_dbz, p_dbz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start && !flush) begin
          m_left       <= lat_of(op, b) - 1;
          {p_hi, p_lo} <= ref_result(op, a, b);
          p_dbz        <= op[1] && (b == 0);
          m_dbz        <= 1'b0;
        end
      end else if (flush) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_dbz  <= p_dbz;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {5'b0, busy, done, div_by_zero, hi, lo},
            {5'b0, m_left != 0, m_done, m_dbz, m_hi, m_lo});
  end

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     output int lat);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", {71'b0, done}, 72'd1);
  endtask

  int lat;
  bit seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    check("reset_state", {5'b0, busy, done, div_by_zero, hi, lo}, 72'd0);

    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_max_lat", 72'(lat), 72'd34);
    check("multu_max_res", {8'b0, hi, lo}, {8'b0, 32'hFFFF_FFFE, 32'h0000_0001});

    run(2'b01, 32'hFFFF_FFF9, 32'd6, lat);
    check("mult_neg_res", {8'b0, hi, lo}, {8'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6});
    run(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_res", {8'b0, hi, lo}, {8'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run(2'b10, 32'd100, 32'd0, lat);
    check("dbz_lat", 72'(lat), 72'd2);
    check("dbz_res", {7'b0, div_by_zero, hi, lo}, {7'b0, 1'b1, 32'd100, 32'hFFFF_FFFF});
    run(2'b10, 32'd100, 32'd7, lat);
    check("divu_res", {7'b0, div_by_zero, hi, lo}, {7'b0, 1'b0, 32'd2, 32'd14});

    // Flush mid-CALC with an ignored start in between
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      if (cyc == 5) begin op = 2'b00; a = 32'd9; b = 32'd9; end
      flush = (cyc == 10);
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {71'b0, busy}, 72'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("flush_no_done", {71'b0, seen_done}, 72'd0);
    check("flush_hold", {8'b0, hi, lo}, {8'b0, 32'd2, 32'd14});

    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_res", {7'b0, div_by_zero, hi, lo}, {7'b0, 1'b0, 32'd0, 32'h8000_0000});

    op = 2'b10; a = 32'd12345; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_calc", {5'b0, busy, done, div_by_zero, hi, lo}, 72'd0);
    repeat (3) @(negedge clk);

    run(2'b00, 32'd5, 32'd3, lat);
`ifdef MDU_EARLY_TERM_EN
    check("multu_small_lat", 72'(lat), 72'd4);
`else
    check("multu_small_lat", 72'(lat), 72'd34);
`endif
    check("multu_small_res", {8'b0, hi, lo}, {8'b0, 32'd0, 32'd15});

    run(2'b11, 32'd7, 32'hFFFF_FFFE, lat);
    check("div_negb_res", {8'b0, hi, lo}, {8'b0, 32'd1, 32'hFFFF_FFFD});
    run(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB, lat);
    check("mult_2neg_res", {8'b0, hi, lo}, {8'b0, 32'd0, 32'd15});
    run(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
    run(2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
    run(2'b10, 32'hFFFF_FFFF, 32'd1, lat);
    run(2'b00, 32'h1234_5678, 32'd0, lat);
    run(2'b11, 32'hFFFF_FFFB, 32'd0, lat);
    check("div_s_dbz_res", {7'b0, div_by_zero, hi, lo}, {7'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run(2'b00, 32'hDEAD_BEEF, 32'h0000_1000, lat);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit, attached beside the ALU in the EX stage of the pipelined CPU. It accepts one operation per start pulse and computes over multiple cycles. It holds busy so the hazard logic can stall the IF/ID/EX registers. Results land in architectural HI/LO registers held inside the block, giving the datapath the mult/div instructions the single-cycle ALU cannot provide.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal range is 8 to 64.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
a  input  WIDTH  multiplicand / dividend, sampled with start
b  input  WIDTH  multiplier / divisor, sampled with start
flush  input  1  abort the in-flight operation (branch/jump flush from EX)
busy  output  1  high while an operation is in progress; drives the pipeline stall
done  output  1  one-cycle pulse on the cycle HI/LO take a new result
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient
div_by_zero  output  1  high together with done when a divide had b == 0; otherwise 0

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0. A reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: busy=0. start=1 and flush=0 latches op, a and b, then goes to CALC at the next edge. start while flush=1 is ignored.
  - CALC: busy=1. One iteration per cycle: shift-add multiply or restoring divide, one bit per cycle. Runs exactly WIDTH iterations.
  - FIN: busy=1 for one cycle. Applies sign correction, writes hi/lo, pulses done=1, then returns to IDLE.
- Latency: start sampled at edge N gives busy=1 from N+1. done=1 and the new hi/lo are visible in the cycle after edge N+WIDTH+1. busy falls in that same cycle. Total is WIDTH+2 cycles start-to-done.
- start while busy=1 is ignored (no queueing). hi/lo are stable between done pulses.
- flush in CALC or FIN: return to IDLE at the next edge. hi/lo/div_by_zero are unchanged and no done pulse is produced. flush has priority over completion in the same cycle.
- Signed ops: operate on magnitudes of two's-complement inputs, then apply signs:
  - product sign = a[MSB] xor b[MSB];
  - quotient sign = a[MSB] xor b[MSB];
  - remainder sign = a[MSB].
  - MULT/MULTU give the full 2*WIDTH product {hi,lo}, with no overflow.
- DIV with most-negative a and b = -1: lo = most-negative value (wraps), hi = 0. No flag is raised.
- Divide by zero (op[1]=1, b=0): CALC is skipped and the unit goes IDLE->FIN directly. done appears the cycle after edge N+1, with lo = all ones, hi = a unmodified, div_by_zero=1.
- div_by_zero is cleared on the next start acceptance or on rst.

Optional Feature:
MDU_EARLY_TERM_EN.
- Defined: for multiply, CALC exits to FIN as soon as the remaining unshifted multiplier magnitude is zero. Latency becomes 2 + (index of highest set bit of |b|) + 1 cycles, with a minimum of 2 cycles when |b| is 0. Divide latency is unchanged. Results are bit-identical to the non-early-terminating version.
- Undefined: multiply latency is fixed at WIDTH+2.

Test Plan:
1. Reset then MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF (WIDTH=32) -> done at cycle 34 after start, hi=0xFFFF_FFFE, lo=0x0000_0001, busy high for cycles 1-33.
2. MULT a=-7 (0xFFFF_FFF9), b=6 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFD6. DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
3. DIVU a=100, b=0 -> done at cycle 2, div_by_zero=1, lo=0xFFFF_FFFF, hi=100. The next DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
4. Start DIVU 1000/3, assert flush at cycle 10 -> busy=0 from cycle 11, no done, hi/lo keep the previous result. A start pulsed at cycle 5 of an active op is ignored.
5. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0, div_by_zero=0. Then assert rst mid-CALC -> all outputs read 0 the next cycle.
6. With MDU_EARLY_TERM_EN: MULTU a=5, b=3 -> done at cycle 4, hi=0, lo=15. Without the macro: done at cycle 34.
